// File: rtl/reservation_station_pkg.sv
// Shared widths, types and the CDB wake-up helper for the ALU/branch
// reservation station.
//
// Contents:
//   OP_WIDTH, ROB_WIDTH          - opcode and ROB tag widths
//   RS_SIZE/RS_WIDTH defaults    - entry count and index width
//   TAG_READY                    - tag value meaning "operand available"
//   operand_t, cdb_t, rs_entry_t - operand, broadcast and entry records
//   snoop_operand()              - applies both CDBs to one operand
package reservation_station_pkg;

    localparam int OP_WIDTH         = 6;
    localparam int ROB_WIDTH        = 4;
    localparam int RS_SIZE_DEFAULT  = 16;
    localparam int RS_WIDTH_DEFAULT = 4;

    // ROB tag 0 is never allocated, so it doubles as "no dependency".
    localparam logic [ROB_WIDTH-1:0] TAG_READY = '0;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] q;
        logic [31:0]          v;
    } operand_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          val;
    } cdb_t;

    typedef struct packed {
        logic                 busy;
        logic [OP_WIDTH-1:0]  opcode;
        operand_t             j;
        operand_t             k;
        logic [31:0]          a;
        logic [ROB_WIDTH:0]   rob_id;
    } rs_entry_t;

    // A pending operand whose tag is on a valid bus takes that value and
    // becomes ready. Tags are unique in flight, so both buses never carry
    // the same tag; the ALU bus is checked first only to keep this total.
    function automatic operand_t snoop_operand(input operand_t op,
                                               input cdb_t     alu,
                                               input cdb_t     lsb);
        operand_t res;
        res = op;
        if (op.q != TAG_READY) begin
            if (alu.valid && alu.tag == op.q) begin
                res.q = TAG_READY;
                res.v = alu.val;
            end else if (lsb.valid && lsb.tag == op.q) begin
                res.q = TAG_READY;
                res.v = lsb.val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_rs_select.sv
// Two lowest-index priority encoders used by the reservation station:
// one over the free-entry vector (dispatch target) and one over the
// ready-entry vector (issue candidate).
//
// Ports:
//   i_free_vec   - 1 per entry that may accept a dispatch
//   i_ready_vec  - 1 per busy entry with both operands available
//   o_free_idx   - lowest set index of i_free_vec (0 when none)
//   o_free_found - i_free_vec has a set bit
//   o_ready_idx  - lowest set index of i_ready_vec (0 when none)
//   o_ready_found- i_ready_vec has a set bit
module reservation_station_rs_select #(
    parameter int RS_SIZE  = 16,
    parameter int RS_WIDTH = 4
) (
    input  logic [RS_SIZE-1:0]  i_free_vec,
    input  logic [RS_SIZE-1:0]  i_ready_vec,
    output logic [RS_WIDTH-1:0] o_free_idx,
    output logic                o_free_found,
    output logic [RS_WIDTH-1:0] o_ready_idx,
    output logic                o_ready_found
);

    // Scanning from the top down lets the lowest set bit be the last write.
    always_comb begin
        o_free_idx    = '0;
        o_free_found  = 1'b0;
        o_ready_idx   = '0;
        o_ready_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (i_free_vec[i]) begin
                o_free_idx   = RS_WIDTH'(i);
                o_free_found = 1'b1;
            end
            if (i_ready_vec[i]) begin
                o_ready_idx   = RS_WIDTH'(i);
                o_ready_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station of the Tomasulo core. Holds dispatched
// ops until both operands are known (from dispatch or from the ALU/LSB
// common data buses) and issues the lowest-index ready entry to the ALU.
//
// Handshake: rdy_disp_in is a valid qualifier with no ready partner; the
// decoder must watch full_out, which rises while one free slot remains so
// a dispatch already in flight still lands. rdy_alu_out is a one-cycle
// valid pulse with no ready partner; the ALU always accepts it.
//
// Ports:
//   clk_in, rst_in           - clock, synchronous active-high reset
//   rdy_in                   - global enable (low freezes all state)
//   clear_in                 - flush all entries on mispredict
//   *_disp_in                - dispatched op: opcode, tags, values, imm, ROB id
//   full_out                 - stall request to the decoder
//   cdb_alu_*_in, cdb_lsb_*_in - broadcast valid/tag/value from each CDB
//   *_alu_out                - issued op, valid on rdy_alu_out
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEFAULT,
    parameter int RS_WIDTH = RS_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,

    input  logic                 rdy_disp_in,
    input  logic [OP_WIDTH-1:0]  opcode_disp_in,
    input  logic [ROB_WIDTH-1:0] qj_disp_in,
    input  logic [ROB_WIDTH-1:0] qk_disp_in,
    input  logic [31:0]          vj_disp_in,
    input  logic [31:0]          vk_disp_in,
    input  logic [31:0]          A_disp_in,
    input  logic [ROB_WIDTH:0]   rob_id_disp_in,
    output logic                 full_out,

    input  logic                 cdb_alu_valid_in,
    input  logic [ROB_WIDTH-1:0] cdb_alu_rob_in,
    input  logic [31:0]          cdb_alu_val_in,
    input  logic                 cdb_lsb_valid_in,
    input  logic [ROB_WIDTH-1:0] cdb_lsb_rob_in,
    input  logic [31:0]          cdb_lsb_val_in,

    output logic                 rdy_alu_out,
    output logic [OP_WIDTH-1:0]  opcode_alu_out,
    output logic [31:0]          v1_alu_out,
    output logic [31:0]          v2_alu_out,
    output logic [31:0]          imm_alu_out,
    output logic [ROB_WIDTH:0]   rob_id_alu_out
);

    rs_entry_t            r_entry [RS_SIZE];
    logic                 r_rdy_alu;
    logic [OP_WIDTH-1:0]  r_opcode_alu;
    logic [31:0]          r_v1_alu;
    logic [31:0]          r_v2_alu;
    logic [31:0]          r_imm_alu;
    logic [ROB_WIDTH:0]   r_rob_id_alu;

    logic [RS_SIZE-1:0]   w_free_vec;
    logic [RS_SIZE-1:0]   w_ready_vec;
    logic [RS_WIDTH:0]    w_free_cnt;
    logic [RS_WIDTH-1:0]  w_free_idx;
    logic                 w_free_found;
    logic [RS_WIDTH-1:0]  w_ready_idx;
    logic                 w_ready_found;
    cdb_t                 w_cdb_alu;
    cdb_t                 w_cdb_lsb;
    rs_entry_t            w_disp_entry;
    logic                 w_disp_fire;

    assign w_cdb_alu = cdb_t'{valid: cdb_alu_valid_in, tag: cdb_alu_rob_in, val: cdb_alu_val_in};
    assign w_cdb_lsb = cdb_t'{valid: cdb_lsb_valid_in, tag: cdb_lsb_rob_in, val: cdb_lsb_val_in};

    // Occupancy views of the start-of-cycle state.
    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        w_free_cnt  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_free_vec[i]  = !r_entry[i].busy;
            w_ready_vec[i] = r_entry[i].busy
                          && (r_entry[i].j.q == TAG_READY)
                          && (r_entry[i].k.q == TAG_READY);
            w_free_cnt     = w_free_cnt + (RS_WIDTH+1)'(!r_entry[i].busy);
        end
    end

    reservation_station_rs_select #(
        .RS_SIZE (RS_SIZE),
        .RS_WIDTH(RS_WIDTH)
    ) u_select (
        .i_free_vec   (w_free_vec),
        .i_ready_vec  (w_ready_vec),
        .o_free_idx   (w_free_idx),
        .o_free_found (w_free_found),
        .o_ready_idx  (w_ready_idx),
        .o_ready_found(w_ready_found)
    );

    // One slot of slack: the decoder sees the stall one op late.
    assign full_out = (w_free_cnt <= (RS_WIDTH+1)'(1));

    // Incoming op with same-cycle CDB bypass already applied, so a tag
    // broadcast while the op is being written is not missed.
    always_comb begin
        w_disp_entry        = '0;
        w_disp_entry.busy   = 1'b1;
        w_disp_entry.opcode = opcode_disp_in;
        w_disp_entry.j      = snoop_operand(operand_t'{q: qj_disp_in, v: vj_disp_in},
                                            w_cdb_alu, w_cdb_lsb);
        w_disp_entry.k      = snoop_operand(operand_t'{q: qk_disp_in, v: vk_disp_in},
                                            w_cdb_alu, w_cdb_lsb);
        w_disp_entry.a      = A_disp_in;
        w_disp_entry.rob_id = rob_id_disp_in;
    end

    // With no free slot the op is dropped (protocol error flagged below).
    assign w_disp_fire = rdy_disp_in && w_free_found;

    // Dispatch targets a free slot and issue frees a busy one, so the two
    // never touch the same entry in one cycle; a slot freed by issue is
    // only visible to dispatch from the next cycle on.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i] <= '0;
            end
            r_rdy_alu    <= 1'b0;
            r_opcode_alu <= '0;
            r_v1_alu     <= '0;
            r_v2_alu     <= '0;
            r_imm_alu    <= '0;
            r_rob_id_alu <= '0;
        end else if (!rdy_in) begin
            r_rdy_alu <= 1'b0;
        end else if (clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i].busy <= 1'b0;
            end
            r_rdy_alu <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_disp_fire && (RS_WIDTH'(i) == w_free_idx)) begin
                    r_entry[i] <= w_disp_entry;
                end else if (w_ready_found && (RS_WIDTH'(i) == w_ready_idx)) begin
                    r_entry[i].busy <= 1'b0;
                end else if (r_entry[i].busy) begin
                    r_entry[i].j <= snoop_operand(r_entry[i].j, w_cdb_alu, w_cdb_lsb);
                    r_entry[i].k <= snoop_operand(r_entry[i].k, w_cdb_alu, w_cdb_lsb);
                end
            end
            r_rdy_alu <= w_ready_found;
            if (w_ready_found) begin
                r_opcode_alu <= r_entry[w_ready_idx].opcode;
                r_v1_alu     <= r_entry[w_ready_idx].j.v;
                r_v2_alu     <= r_entry[w_ready_idx].k.v;
                r_imm_alu    <= r_entry[w_ready_idx].a;
                r_rob_id_alu <= r_entry[w_ready_idx].rob_id;
            end
        end
    end

    // Dispatch into a full station is a decoder bug; flag it in simulation.
    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && !clear_in && rdy_disp_in) begin
            assert (w_free_found)
            else $error("reservation_station: dispatch with no free entry, op dropped");
        end
    end

    assign rdy_alu_out    = r_rdy_alu;
    assign opcode_alu_out = r_opcode_alu;
    assign v1_alu_out     = r_v1_alu;
    assign v2_alu_out     = r_v2_alu;
    assign imm_alu_out    = r_imm_alu;
    assign rob_id_alu_out = r_rob_id_alu;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed
// by randomized traffic, all predicted by a slot-array reference model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N     = 16;
    localparam int OUT_W = OP_WIDTH + 96 + ROB_WIDTH + 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk_in = 1'b0;
    logic                 rst_in, rdy_in, clear_in;
    logic                 rdy_disp_in;
    logic [OP_WIDTH-1:0]  opcode_disp_in;
    logic [ROB_WIDTH-1:0] qj_disp_in, qk_disp_in;
    logic [31:0]          vj_disp_in, vk_disp_in, A_disp_in;
    logic [ROB_WIDTH:0]   rob_id_disp_in;
    logic                 full_out;
    logic                 cdb_alu_valid_in, cdb_lsb_valid_in;
    logic [ROB_WIDTH-1:0] cdb_alu_rob_in, cdb_lsb_rob_in;
    logic [31:0]          cdb_alu_val_in, cdb_lsb_val_in;
    logic                 rdy_alu_out;
    logic [OP_WIDTH-1:0]  opcode_alu_out;
    logic [31:0]          v1_alu_out, v2_alu_out, imm_alu_out;
    logic [ROB_WIDTH:0]   rob_id_alu_out;

    always #5 clk_in = ~clk_in;

    reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .rdy_disp_in(rdy_disp_in), .opcode_disp_in(opcode_disp_in),
        .qj_disp_in(qj_disp_in), .qk_disp_in(qk_disp_in),
        .vj_disp_in(vj_disp_in), .vk_disp_in(vk_disp_in),
        .A_disp_in(A_disp_in), .rob_id_disp_in(rob_id_disp_in),
        .full_out(full_out),
        .cdb_alu_valid_in(cdb_alu_valid_in), .cdb_alu_rob_in(cdb_alu_rob_in),
        .cdb_alu_val_in(cdb_alu_val_in),
        .cdb_lsb_valid_in(cdb_lsb_valid_in), .cdb_lsb_rob_in(cdb_lsb_rob_in),
        .cdb_lsb_val_in(cdb_lsb_val_in),
        .rdy_alu_out(rdy_alu_out), .opcode_alu_out(opcode_alu_out),
        .v1_alu_out(v1_alu_out), .v2_alu_out(v2_alu_out),
        .imm_alu_out(imm_alu_out), .rob_id_alu_out(rob_id_alu_out)
    );

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [OUT_W-1:0] exp_q[$];

    bit                   m_busy [N];
    logic [OP_WIDTH-1:0]  m_op   [N];
    logic [ROB_WIDTH-1:0] m_qj   [N];
    logic [ROB_WIDTH-1:0] m_qk   [N];
    logic [31:0]          m_vj   [N];
    logic [31:0]          m_vk   [N];
    logic [31:0]          m_a    [N];
    logic [ROB_WIDTH:0]   m_rob  [N];
    bit                   m_rdy  = 1'b0;
    bit                   m_full = 1'b0;
    bit                   mon_en = 1'b0;

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < N; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    // Operand after this cycle's broadcasts: {tag, value}.
    function automatic logic [ROB_WIDTH+31:0] wake(input logic [ROB_WIDTH-1:0] q,
                                                    input logic [31:0] v);
        if (q != 0 && cdb_alu_valid_in && cdb_alu_rob_in == q) return {ROB_WIDTH'(0), cdb_alu_val_in};
        if (q != 0 && cdb_lsb_valid_in && cdb_lsb_rob_in == q) return {ROB_WIDTH'(0), cdb_lsb_val_in};
        return {q, v};
    endfunction

    // Advances the model across one clock edge using the inputs now driven.
    task automatic model_step();
        int fi, ri;
        if (rst_in || (rdy_in && clear_in)) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_rdy = 1'b0;
        end else if (!rdy_in) begin
            m_rdy = 1'b0;
        end else begin
            fi = -1;
            ri = -1;
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i] && fi < 0) fi = i;
                if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && ri < 0) ri = i;
            end
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    {m_qj[i], m_vj[i]} = wake(m_qj[i], m_vj[i]);
                    {m_qk[i], m_vk[i]} = wake(m_qk[i], m_vk[i]);
                end
            end
            m_rdy = (ri >= 0);
            if (ri >= 0) begin
                exp_q.push_back({m_op[ri], m_vj[ri], m_vk[ri], m_a[ri], m_rob[ri]});
                m_busy[ri] = 1'b0;
            end
            if (rdy_disp_in && fi >= 0) begin
                m_busy[fi] = 1'b1;
                m_op[fi]   = opcode_disp_in;
                {m_qj[fi], m_vj[fi]} = wake(qj_disp_in, vj_disp_in);
                {m_qk[fi], m_vk[fi]} = wake(qk_disp_in, vk_disp_in);
                m_a[fi]    = A_disp_in;
                m_rob[fi]  = rob_id_disp_in;
            end
        end
        m_full = (model_free() <= 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        logic [OUT_W-1:0] got, want;
        bit has_want;
        if (mon_en) begin
            checks++;
            if (rdy_alu_out !== m_rdy) begin
                errors++;
                $display("FAIL rdy_alu_out got %b exp %b at %0t", rdy_alu_out, m_rdy, $time);
            end
            checks++;
            if (full_out !== m_full) begin
                errors++;
                $display("FAIL full_out got %b exp %b at %0t", full_out, m_full, $time);
            end
            has_want = 1'b0;
            want     = '0;
            if (m_rdy && exp_q.size() > 0) begin
                want     = exp_q.pop_front();
                has_want = 1'b1;
            end
            if (rdy_alu_out === 1'b1) begin
                got = {opcode_alu_out, v1_alu_out, v2_alu_out, imm_alu_out, rob_id_alu_out};
                checks++;
                if (!has_want || got !== want) begin
                    errors++;
                    $display("FAIL issue_fields got %h exp %h at %0t", got, want, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk_in);
        #1;
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1;  clear_in = 1'b0;  rdy_disp_in = 1'b0;
        opcode_disp_in = '0; qj_disp_in = '0; qk_disp_in = '0;
        vj_disp_in = '0; vk_disp_in = '0; A_disp_in = '0; rob_id_disp_in = '0;
        cdb_alu_valid_in = 1'b0; cdb_alu_rob_in = '0; cdb_alu_val_in = '0;
        cdb_lsb_valid_in = 1'b0; cdb_lsb_rob_in = '0; cdb_lsb_val_in = '0;
    endtask

    task automatic disp(input logic [OP_WIDTH-1:0] op, input logic [ROB_WIDTH-1:0] qj,
                        input logic [31:0] vj, input logic [ROB_WIDTH-1:0] qk,
                        input logic [31:0] vk, input logic [31:0] a,
                        input logic [ROB_WIDTH:0] rob);
        rdy_disp_in = 1'b1; opcode_disp_in = op;
        qj_disp_in = qj; vj_disp_in = vj; qk_disp_in = qk; vk_disp_in = vk;
        A_disp_in = a; rob_id_disp_in = rob;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst_in = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("reset_rdy",    64'(rdy_alu_out), 64'(0));
        chk("reset_opcode", 64'(opcode_alu_out), 64'(0));
        chk("reset_v1",     64'(v1_alu_out), 64'(0));
        chk("reset_v2",     64'(v2_alu_out), 64'(0));
        chk("reset_imm",    64'(imm_alu_out), 64'(0));
        chk("reset_rob",    64'(rob_id_alu_out), 64'(0));
        chk("reset_full",   64'(full_out), 64'(0));
        rst_in = 1'b0;
        tick();

        // 1: ready operands issue two edges after dispatch
        disp(6'd1, 4'd0, 32'd5, 4'd0, 32'd7, 32'd0, 5'd3);
        tick();
        idle_inputs();
        chk("t1_no_early_issue", 64'(rdy_alu_out), 64'(0));
        tick();
        chk("t1_rdy", 64'(rdy_alu_out), 64'(1));
        chk("t1_v1",  64'(v1_alu_out), 64'(5));
        chk("t1_v2",  64'(v2_alu_out), 64'(7));
        chk("t1_rob", 64'(rob_id_alu_out), 64'(3));
        chk("t1_full", 64'(full_out), 64'(0));

        // 2: ALU CDB wakes a pending operand
        disp(6'd2, 4'd4, 32'd0, 4'd0, 32'd9, 32'd0, 5'd4);
        tick();
        idle_inputs();
        tick();
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 4'd4; cdb_alu_val_in = 32'h1234;
        tick();
        idle_inputs();
        chk("t2_wait_after_wake", 64'(rdy_alu_out), 64'(0));
        tick();
        chk("t2_rdy", 64'(rdy_alu_out), 64'(1));
        chk("t2_v1",  64'(v1_alu_out), 64'(32'h1234));
        chk("t2_v2",  64'(v2_alu_out), 64'(9));

        // 3: same-cycle LSB bypass at dispatch
        disp(6'd3, 4'd6, 32'd0, 4'd0, 32'd1, 32'd0, 5'd6);
        cdb_lsb_valid_in = 1'b1; cdb_lsb_rob_in = 4'd6; cdb_lsb_val_in = 32'hAB;
        tick();
        idle_inputs();
        tick();
        chk("t3_rdy", 64'(rdy_alu_out), 64'(1));
        chk("t3_v1",  64'(v1_alu_out), 64'(32'hAB));

        // 4: fill 15 entries waiting on tag 2, then drain in index order
        for (int i = 0; i < 15; i++) begin
            disp(6'd4, 4'd2, 32'd0, 4'd0, 32'(i), 32'(100 + i), 5'(i + 1));
            tick();
            if (i == 13) chk("t4_full_at_14", 64'(full_out), 64'(0));
        end
        idle_inputs();
        chk("t4_full_at_15", 64'(full_out), 64'(1));
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 4'd2; cdb_alu_val_in = 32'hCAFE;
        tick();
        idle_inputs();
        tick();
        chk("t4_first_rob", 64'(rob_id_alu_out), 64'(1));
        chk("t4_full_drop", 64'(full_out), 64'(0));
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("t4_order_rob", 64'(rob_id_alu_out), 64'(i + 1));
        end
        tick();
        chk("t4_drained", 64'(rdy_alu_out), 64'(0));

        // 5: flush drops pending entries; next dispatch issues normally
        for (int i = 0; i < 3; i++) begin
            disp(6'd5, 4'd5, 32'd0, 4'd0, 32'd0, 32'd0, 5'(20 + i));
            tick();
        end
        idle_inputs();
        clear_in = 1'b1;
        tick();
        idle_inputs();
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 4'd5; cdb_alu_val_in = 32'h55;
        tick();
        idle_inputs();
        tick();
        chk("t5_no_issue_after_clear", 64'(rdy_alu_out), 64'(0));
        chk("t5_full_after_clear", 64'(full_out), 64'(0));
        disp(6'd6, 4'd0, 32'd11, 4'd0, 32'd12, 32'd13, 5'd12);
        tick();
        idle_inputs();
        tick();
        chk("t5_new_rob", 64'(rob_id_alu_out), 64'(12));

        // 6: pause holds the ready entry
        disp(6'd7, 4'd0, 32'd21, 4'd0, 32'd22, 32'd23, 5'd9);
        tick();
        idle_inputs();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_paused", 64'(rdy_alu_out), 64'(0));
        end
        rdy_in = 1'b1;
        tick();
        chk("t6_resume_rdy", 64'(rdy_alu_out), 64'(1));
        chk("t6_resume_rob", 64'(rob_id_alu_out), 64'(9));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 79) == 0);
            if (model_free() > 0 && $urandom_range(0, 2) != 0) begin
                disp(OP_WIDTH'($urandom_range(0, 63)),
                     ($urandom_range(0, 1) != 0) ? 4'd0 : ROB_WIDTH'($urandom_range(1, 7)),
                     $urandom,
                     ($urandom_range(0, 1) != 0) ? 4'd0 : ROB_WIDTH'($urandom_range(1, 7)),
                     $urandom, $urandom, 5'($urandom_range(1, 31)));
            end
            if ($urandom_range(0, 4) < 2) begin
                cdb_alu_valid_in = 1'b1;
                cdb_alu_rob_in   = ROB_WIDTH'($urandom_range(1, 7));
                cdb_alu_val_in   = $urandom;
            end
            if ($urandom_range(0, 4) < 2) begin
                cdb_lsb_valid_in = 1'b1;
                cdb_lsb_rob_in   = ROB_WIDTH'($urandom_range(1, 7));
                if (cdb_alu_valid_in && cdb_lsb_rob_in == cdb_alu_rob_in)
                    cdb_lsb_rob_in = (cdb_alu_rob_in == 4'd7) ? 4'd1 : cdb_alu_rob_in + 4'd1;
                cdb_lsb_val_in   = $urandom;
            end
            tick();
        end

        // wake every tag still outstanding, then drain
        for (int t = 1; t <= 7; t++) begin
            idle_inputs();
            cdb_alu_valid_in = 1'b1;
            cdb_alu_rob_in   = ROB_WIDTH'(t);
            cdb_alu_val_in   = 32'(t * 3);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 24; i++) tick();
        @(negedge clk_in);
        #1;
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("final_full", 64'(full_out), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatch-to-RS interface in the Tomasulo core.
- Accepts one dispatched ALU/branch op per cycle with operand values or ROB tags.
- Snoops the ALU and LSB common data buses (CDB) and fills pending operands when their tag is broadcast.
- Issues at most one fully-ready entry per cycle to the ALU.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_WIDTH, 4, log2(RS_SIZE).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low = pause, hold all state.
- clear_in  in  1  ROB flush on mispredict.
- rdy_disp_in  in  1  dispatch valid.
- opcode_disp_in  in  OP_WIDTH  opcode.
- qj_disp_in, qk_disp_in  in  ROB_WIDTH  each  pending-operand tags; 0 = operand ready.
- vj_disp_in, vk_disp_in  in  32  each  operand values.
- A_disp_in  in  32  immediate.
- rob_id_disp_in  in  ROB_WIDTH+1  destination ROB id.
- full_out  out  1  stall request to the decoder.
- cdb_alu_valid_in  in  1  ALU CDB broadcast valid.
- cdb_alu_rob_in  in  ROB_WIDTH  ALU CDB tag.
- cdb_alu_val_in  in  32  ALU CDB value.
- cdb_lsb_valid_in  in  1  LSB CDB broadcast valid.
- cdb_lsb_rob_in  in  ROB_WIDTH  LSB CDB tag.
- cdb_lsb_val_in  in  32  LSB CDB value.
- rdy_alu_out  out  1  issue valid, one-cycle pulse.
- opcode_alu_out  out  OP_WIDTH  issued opcode.
- v1_alu_out, v2_alu_out  out  32  each  issued operand values.
- imm_alu_out  out  32  issued immediate.
- rob_id_alu_out  out  ROB_WIDTH+1  issued ROB id.

Behaviour:
- Clock and reset: one clock, clk_in; synchronous active-high reset rst_in. All state updates at the posedge.
- Reset effect: all entries invalid; rdy_alu_out=0; all other ALU outputs 0; full_out=0.
- Tag encoding: ROB tag 0 is never allocated, so tag 0 means "no dependency".
- Entry contents: busy, opcode, qj, qk, vj, vk, A, rob_id.

Dispatch:
- Occurs when rdy_in && rdy_disp_in && !clear_in.
- Written to the lowest-index non-busy entry as seen at the start of the cycle; valid after the edge.
- Same-cycle CDB bypass: if incoming qj/qk matches a valid CDB tag this cycle (nonzero), store the CDB value and set q to 0.

Snoop:
- Every busy entry with q != 0 and q == a valid CDB tag takes that value and clears q.
- ALU and LSB CDBs are checked independently; each can resolve a different operand in the same cycle.

Issue:
- Each cycle with rdy_in, the lowest-index busy entry with qj==0 && qk==0 (start-of-cycle state) is selected.
- That entry is freed; next cycle rdy_alu_out=1 with its fields registered.
- Latency: dispatch at edge T with ready operands -> rdy_alu_out high after edge T+1.
- An entry woken by the CDB at edge T issues at edge T+1 at the earliest.
- No ready entry -> rdy_alu_out=0; other ALU outputs hold their last values.
- A slot freed by issue is reusable by dispatch in the following cycle, never the same cycle.

Full:
- full_out is combinational; it is 1 when free entries <= 1 (one-cycle slack for the combinational dispatcher).
- Dispatch while 0 free entries is a protocol error: the op is dropped and a simulation $display error is raised.

Flush and pause:
- clear_in (when rdy_in): all entries invalid, rdy_alu_out=0 next cycle, same-cycle dispatch and issue suppressed.
- clear_in takes priority over dispatch, snoop and issue.
- rdy_in low: no state change; rdy_alu_out forced 0 next cycle; CDB inputs ignored (whole core paused).

Reset:
- Reset mid-operation has the same effect as clear_in plus output zeroing; reset dominates rdy_in.

Decomposition:
- define.vh: OP_WIDTH, ROB_WIDTH, RS_SIZE/RS_WIDTH defaults, tag-0 "ready" constant.
- Sub-module rs_select: two lowest-index priority encoders (free vector, ready vector) returning index plus found flag, parameterised on RS_SIZE.

Test Plan:
1. Dispatch ADD, qj=qk=0, vj=5, vk=7, rob_id=3 -> rdy_alu_out=1 two edges later with v1=5, v2=7, rob_id=3; full_out stays 0.
2. Dispatch qj=4, vk=9; two cycles later ALU CDB tag 4 val 0x1234 -> entry issues the cycle after the CDB edge with v1=0x1234, v2=9.
3. Dispatch qj=6 in the same cycle LSB CDB broadcasts tag 6 val 0xAB -> issue two edges later with v1=0xAB (bypass).
4. Fill 15 entries with qj=2 -> full_out=1 at 15; ALU CDB tag 2 -> entries issue one per cycle in index order 0..14; full_out drops after the first issue.
5. Entries pending, assert clear_in one cycle -> no rdy_alu_out afterwards; new dispatch lands at index 0.
6. Hold rdy_in low while a ready entry exists -> rdy_alu_out=0 throughout; issue resumes the cycle after rdy_in rises.
